// File: rtl/demux8x32_pkg.sv
// demux8x32_pkg: shared widths for the 8-channel 32-bit handshake demux
package demux8x32_pkg;
  localparam int DW    = 32;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 16;
endpackage

// File: rtl/demux8x32_hs_slot.sv
// demux_slot: one-entry valid/data buffer with load, drain and flush
module demux_slot
  import demux8x32_pkg::*;
(
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] din,
  output logic          valid,
  output logic [DW-1:0] data
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  // a load in the same cycle as a drain keeps the slot full with the new word
  always_comb begin
    valid_d = flush ? 1'b0 : (load | (valid_q & ~drain));
    data_d  = (load & ~flush) ? din : data_q;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/demux8x32_hs.sv
// demux8x32_hs: 1-to-8 valid/ready demux of 32-bit words into one-entry channel buffers
// DEMUX8X32_XFER_CNT_EN enables the accepted-transfer counter on xfer_cnt
module demux8x32_hs
  import demux8x32_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [DW-1:0]    in_data,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ready,
  output logic [DW-1:0]    y0,
  output logic [DW-1:0]    y1,
  output logic [DW-1:0]    y2,
  output logic [DW-1:0]    y3,
  output logic [DW-1:0]    y4,
  output logic [DW-1:0]    y5,
  output logic [DW-1:0]    y6,
  output logic [DW-1:0]    y7,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic          accept;
  logic [DW-1:0] y_arr [NCH];
  always_comb begin
    in_ready = ~flush & (~out_valid[in_sel] | out_ready[in_sel]);
    accept   = in_valid & in_ready;
  end
  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot u_slot (
      .clk   (clk),
      .clrn  (clrn),
      .flush (flush),
      .load  (accept && (in_sel == SEL_W'(i))),
      .drain (out_ready[i]),
      .din   (in_data),
      .valid (out_valid[i]),
      .data  (y_arr[i])
    );
  end
  assign y0 = y_arr[0];
  assign y1 = y_arr[1];
  assign y2 = y_arr[2];
  assign y3 = y_arr[3];
  assign y4 = y_arr[4];
  assign y5 = y_arr[5];
  assign y6 = y_arr[6];
  assign y7 = y_arr[7];
`ifdef DEMUX8X32_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = flush ? '0 : cnt_q + CNT_W'(accept);
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_demux8x32_hs.sv
// tb_demux8x32_hs: directed self-checking bench for demux8x32_hs
module tb_demux8x32_hs;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = 3'd0;
  logic [31:0] in_data = 32'h0;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = 8'h00;
  logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [15:0] xfer_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux8x32_hs dut (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .xfer_cnt(xfer_cnt)
  );

  function automatic logic [31:0] yv(input int i);
    case (i)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] sel, input logic [31:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    #2;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
    checks++;
    if (xfer_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", xfer_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (yv(i) !== 32'h0) begin failures++; $display("FAIL reset_y%0d got=%h exp=00000000", i, yv(i)); end
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_flush got=%b exp=0", in_ready); end
    flush = 1'b0;
    step();
    clrn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hDEADBEEF; out_ready = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_pre got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h08) begin failures++; $display("FAIL basic_valid got=%h exp=08", out_valid); end
    checks++;
    if (y3 !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_y3 got=%h exp=deadbeef", y3); end
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_sel3 got=%b exp=0", in_ready); end
    in_sel = 3'd0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_sel0 got=%b exp=1", in_ready); end
    // blocked producer holding a word for full channel 3
    push(3'd3, 32'hCAFEF00D);
    checks++;
    if (y3 !== 32'hDEADBEEF || out_valid !== 8'h08) begin
      failures++; $display("FAIL hold_blocked got=%h/%h exp=deadbeef/08", y3, out_valid);
    end
    out_ready = 8'h08;
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL drain_valid got=%h exp=00", out_valid); end
    checks++;
    if (y3 !== 32'hDEADBEEF) begin failures++; $display("FAIL drain_keeps_y3 got=%h exp=deadbeef", y3); end
  endtask

  task automatic test_back_to_back();
    push(3'd5, 32'hAAAA0005);
    checks++;
    if (out_valid !== 8'h20 || y5 !== 32'hAAAA0005) begin
      failures++; $display("FAIL b2b_first got=%h/%h exp=20/aaaa0005", out_valid, y5);
    end
    out_ready = 8'h20; in_valid = 1'b1; in_sel = 3'd5; in_data = 32'h12345678;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h20 || y5 !== 32'h12345678) begin
      failures++; $display("FAIL b2b_second got=%h/%h exp=20/12345678", out_valid, y5);
    end
    step();
    out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL b2b_drain got=%h exp=00", out_valid); end
  endtask

  task automatic test_flush();
    push(3'd0, 32'h11111111);
    push(3'd2, 32'h22222222);
    push(3'd7, 32'h77777777);
    checks++;
    if (out_valid !== 8'h85) begin failures++; $display("FAIL flush_pre got=%h exp=85", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_sel = 3'd1; in_data = 32'h99999999; out_ready = 8'h00;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL flush_valid got=%h exp=00", out_valid); end
    checks++;
    if (y0 !== 32'h11111111 || y2 !== 32'h22222222 || y7 !== 32'h77777777) begin
      failures++; $display("FAIL flush_data got=%h/%h/%h exp=11111111/22222222/77777777", y0, y2, y7);
    end
    checks++;
    if (y1 !== 32'h0) begin failures++; $display("FAIL flush_no_accept got=%h exp=00000000", y1); end
  endtask

  task automatic test_cross();
    push(3'd1, 32'h01010101);
    out_ready = 8'h02; in_valid = 1'b1; in_sel = 3'd6; in_data = 32'h66666666;
    step();
    in_valid = 1'b0; out_ready = 8'h00;
    checks++;
    if (out_valid !== 8'h40) begin failures++; $display("FAIL cross_valid got=%h exp=40", out_valid); end
    checks++;
    if (y6 !== 32'h66666666 || y1 !== 32'h01010101) begin
      failures++; $display("FAIL cross_data got=%h/%h exp=66666666/01010101", y6, y1);
    end
    out_ready = 8'h40;
    step();
    out_ready = 8'h00;
  endtask

  task automatic test_async_reset();
    push(3'd2, 32'h2222AAAA);
    push(3'd4, 32'h4444BBBB);
    checks++;
    if (out_valid !== 8'h14) begin failures++; $display("FAIL arst_pre got=%h exp=14", out_valid); end
    #2;
    clrn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 8'h00) begin failures++; $display("FAIL arst_valid got=%h exp=00", out_valid); end
    checks++;
    if (y2 !== 32'h0 || y4 !== 32'h0) begin
      failures++; $display("FAIL arst_data got=%h/%h exp=0/0", y2, y4);
    end
    #1;
    clrn = 1'b1;
    in_sel = 3'd4;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    push(3'd4, 32'h0BAD0004);
    checks++;
    if (out_valid !== 8'h10 || y4 !== 32'h0BAD0004) begin
      failures++; $display("FAIL arst_reaccept got=%h/%h exp=10/0bad0004", out_valid, y4);
    end
    out_ready = 8'h10;
    step();
    out_ready = 8'h00;
  endtask

  task automatic test_xfer_cnt();
`ifdef DEMUX8X32_XFER_CNT_EN
    clrn = 1'b0;
    #2;
    clrn = 1'b1;
    step();
    out_ready = 8'hFF; in_valid = 1'b1; in_sel = 3'd0;
    for (int n = 0; n < 65537; n++) begin
      in_data = n;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (xfer_cnt !== 16'h0001) begin failures++; $display("FAIL cnt_wrap got=%h exp=0001", xfer_cnt); end
    push(3'd1, 32'h1);
    checks++;
    if (xfer_cnt !== 16'h0002) begin failures++; $display("FAIL cnt_incr got=%h exp=0002", xfer_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 8'h00;
    checks++;
    if (xfer_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_flush got=%h exp=0000", xfer_cnt); end
`else
    out_ready = 8'hFF;
    for (int n = 0; n < 5; n++) push(3'(n), 32'hC0 + n);
    out_ready = 8'h00;
    checks++;
    if (xfer_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_const got=%h exp=0000", xfer_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_cross();
    test_async_reset();
    test_xfer_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
